bundle_issue_buffer: RTL and testbench
======================================

// Module: bundle_issue_buffer
// PURPOSE
//  Consumer side of the 4-wide branch filter: takes a fetch bundle of four instructions plus per-slot
//  valid bits, compacts the valid slots in program order (slot 1 oldest) and stores them in a circular
//  buffer. Drains one instruction per cycle to decode via valid/ready. Flushed on branch redirect.
// PARAMETERS
//  INSTR_W  16  instruction width; opcode = bits [INSTR_W-1 -: 4]
//  DEPTH    8   buffer entries; power of two, >= 4
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  flush        in   1        redirect: discard all stored and incoming instructions
//  in_ins1..4   in   INSTR_W  bundle slots, slot 1 oldest
//  in_vld1..4   in   1        per-slot valid from the branch filter (any pattern legal, holes allowed)
//  in_rdy       out  1        bundle accepted this cycle if in_rdy=1
//  out_ins      out  INSTR_W  oldest buffered instruction
//  out_vld      out  1        out_ins valid
//  out_rdy      in   1        decode accepts out_ins
//  out_is_br    out  1        out_vld & opcode(out_ins)==OP_BRANCH
//  count        out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  - Reset (async assert, sync release): rd_ptr=wr_ptr=0, count=0; out_vld=0, out_is_br=0, in_rdy=1.
//  - n = popcount(in_vld1..4). in_rdy = ~flush & (DEPTH-count >= 4), from registered count only; a pop
//    in the same cycle does not create room. Push when in_rdy & n>0; n=0 bundle is a no-op.
//  - Compaction: k-th set valid bit (slot order) writes mem[(wr_ptr+k) mod DEPTH], k=0..n-1;
//    wr_ptr += n. Invalid slots never stored; their data is don't-care.
//  - Pop when out_vld & out_rdy: rd_ptr += 1. out_ins = mem[rd_ptr], out_vld = (count!=0).
//  - Pointers $clog2(DEPTH) bits, wrap naturally; count separate, range 0..DEPTH.
//  - Simultaneous push+pop: count_next = count + n - 1. Write to entry being read same cycle impossible
//    (count>0 on pop, writes go to free slots).
//  - Latency: pushed instruction visible on out_ins the cycle after push (no bypass).
//  - out_ins/out_vld hold stable while out_vld & ~out_rdy.
//  - flush (highest priority): next cycle rd_ptr=wr_ptr=0, count=0, out_vld=0; that cycle's bundle and
//    any pop are discarded (in_rdy=0 while flush high, so producer retries).
//  - Reset mid-operation: immediate return to reset state, contents lost.
// STRUCTURE
//  - Shared package: OP_BRANCH = 4'b0001, INSTR_W default, opcode field slice function.
//  - Sub-module bundle_compact: combinational; in_vld[4], in_ins[4] -> n (3b), packed[4] in order.
//  - Top: storage array, pointers, count, handshake logic.
// TESTING
//  1 Reset: rst_n=0 mid-traffic -> out_vld=0, count=0, in_rdy=1 immediately, no pops after release.
//  2 Holes: vld=1010, ins=A,B,C,D -> out A then C on consecutive cycles (out_rdy=1), count 2->1->0.
//  3 Full: out_rdy=0, push 4x vld=1111 into DEPTH=8 -> two accepted, count=8, in_rdy=0; pop one ->
//    count=7, in_rdy still 0 (needs >=4 free).
//  4 Wrap: push/pop 20 bundles vld=0111 with out_rdy=1 -> output order exact, pointers wrap, no loss.
//  5 Push+pop same cycle: count=4, vld=1100, pop -> count=5; order preserved.
//  6 Flush: count=5, flush=1 with vld=1111 offered -> in_rdy=0; next cycle count=0, out_vld=0; branch
//    op 0001 at head before flush -> out_is_br=1 only while out_vld.

Source files
------------

// File: rtl/bundle_issue_buffer_pkg.sv
// bundle_issue_buffer_pkg
//  Shared definitions for the bundle issue buffer: default sizes, the branch
//  opcode value and a helper that extracts the opcode field from an instruction.
package bundle_issue_buffer_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int DEPTH_DEF   = 8;
    // Widest instruction the opcode helper accepts.
    localparam int MAX_INSTR_W = 64;

    localparam logic [3:0] OP_BRANCH = 4'b0001;

    // Opcode is the top four bits of a w-bit instruction.
    // The instruction is zero-extended to MAX_INSTR_W before the call.
    function automatic logic [3:0] opcode_of(input logic [MAX_INSTR_W-1:0] ins,
                                             input int unsigned            w);
        logic [MAX_INSTR_W-1:0] shifted;
        shifted = ins >> (w - 32'd4);
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/bundle_issue_buffer_compact.sv
// bundle_compact
//  Combinational compaction of a four-slot fetch bundle. Valid slots are packed
//  toward index 0 in program order (slot index 0 is the oldest).
//  Ports:
//   in_vld[3:0]    per-slot valid, bit 0 = oldest slot
//   in_ins[4]      slot instructions
//   n              number of valid slots (0..4)
//   packed_ins[4]  valid instructions, oldest first; entries >= n are zero
module bundle_compact
    import bundle_issue_buffer_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic [3:0]         in_vld,
    input  logic [INSTR_W-1:0] in_ins     [4],
    output logic [2:0]         n,
    output logic [INSTR_W-1:0] packed_ins [4]
);

    // Walk the slots oldest-first; each valid one takes the next packed position.
    always_comb begin
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 4; i++) begin
            packed_ins[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            if (in_vld[i]) begin
                packed_ins[idx[1:0]] = in_ins[i];
                idx                  = idx + 3'd1;
            end else begin
                idx = idx;
            end
        end
        n = idx;
    end

endmodule

// File: rtl/bundle_issue_buffer.sv
// bundle_issue_buffer
//  Accepts four-wide fetch bundles with arbitrary per-slot valid patterns,
//  compacts the valid instructions in program order into a circular buffer and
//  drains one instruction per cycle to decode. A flush discards everything.
//  Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                redirect; clears the buffer and refuses the bundle
//   in_ins1..4/in_vld1..4  bundle slots (slot 1 oldest) and their valids
//   in_rdy               bundle accepted this cycle when high
//   out_ins/out_vld/out_rdy  head instruction handshake toward decode
//   out_is_br            head instruction is a branch
//   count                number of entries held (0..DEPTH)
module bundle_issue_buffer
    import bundle_issue_buffer_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [INSTR_W-1:0]       in_ins1,
    input  logic [INSTR_W-1:0]       in_ins2,
    input  logic [INSTR_W-1:0]       in_ins3,
    input  logic [INSTR_W-1:0]       in_ins4,
    input  logic                     in_vld1,
    input  logic                     in_vld2,
    input  logic                     in_vld3,
    input  logic                     in_vld4,
    output logic                     in_rdy,
    output logic [INSTR_W-1:0]       out_ins,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_is_br,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [INSTR_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]      rd_ptr_r;
    logic [PW-1:0]      wr_ptr_r;
    logic [CW-1:0]      count_r;

    logic [INSTR_W-1:0] ins_arr_s    [4];
    logic [INSTR_W-1:0] packed_ins_s [4];
    logic [2:0]         n_s;
    logic [PW-1:0]      wr_idx_s     [4];
    logic               push_s;
    logic               pop_s;
    logic [CW-1:0]      count_next_s;
    logic [PW-1:0]      rd_ptr_next_s;
    logic [PW-1:0]      wr_ptr_next_s;

    assign ins_arr_s[0] = in_ins1;
    assign ins_arr_s[1] = in_ins2;
    assign ins_arr_s[2] = in_ins3;
    assign ins_arr_s[3] = in_ins4;

    bundle_compact #(
        .INSTR_W (INSTR_W)
    ) u_compact (
        .in_vld     ({in_vld4, in_vld3, in_vld2, in_vld1}),
        .in_ins     (ins_arr_s),
        .n          (n_s),
        .packed_ins (packed_ins_s)
    );

    // Room is judged from the registered count only: a pop this cycle does not
    // make space for this cycle's bundle, which keeps in_rdy off the out_rdy path.
    assign in_rdy    = ~flush & ((CW'(DEPTH) - count_r) >= CW'(4));
    assign out_vld   = (count_r != CW'(0));
    assign out_ins   = mem_r[rd_ptr_r];
    assign out_is_br = out_vld & (opcode_of(MAX_INSTR_W'(out_ins), INSTR_W) == OP_BRANCH);
    assign count     = count_r;

    // Handshake qualification and next-state for pointers and occupancy.
    always_comb begin
        push_s        = in_rdy & (n_s != 3'd0);
        pop_s         = out_vld & out_rdy & ~flush;
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        count_next_s  = count_r;
        for (int k = 0; k < 4; k++) begin
            wr_idx_s[k] = wr_ptr_r + PW'(k);
        end
        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + PW'(n_s);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        count_next_s = count_r + (push_s ? CW'(n_s) : CW'(0)) - (pop_s ? CW'(1) : CW'(0));
    end

    // Pointer and occupancy registers; flush returns them to the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_next_s;
            wr_ptr_r <= wr_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // Storage writes: packed entry k lands at wr_ptr+k. These slots are always
    // free, so a write never targets the entry being read in the same cycle.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (push_s && (3'(k) < n_s)) begin
                mem_r[wr_idx_s[k]] <= packed_ins_s[k];
            end
        end
    end

endmodule

// File: tb/tb_bundle_issue_buffer.sv
// tb_bundle_issue_buffer
//  Directed self-checking bench for bundle_issue_buffer (INSTR_W=16, DEPTH=8).
//  Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_bundle_issue_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] in_ins1, in_ins2, in_ins3, in_ins4;
    logic        in_vld1, in_vld2, in_vld3, in_vld4;
    logic        in_rdy;
    logic [15:0] out_ins;
    logic        out_vld;
    logic        out_rdy;
    logic        out_is_br;
    logic [3:0]  count;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    bundle_issue_buffer #(
        .INSTR_W (16),
        .DEPTH   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_ins1   (in_ins1),
        .in_ins2   (in_ins2),
        .in_ins3   (in_ins3),
        .in_ins4   (in_ins4),
        .in_vld1   (in_vld1),
        .in_vld2   (in_vld2),
        .in_vld3   (in_vld3),
        .in_vld4   (in_vld4),
        .in_rdy    (in_rdy),
        .out_ins   (out_ins),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_is_br (out_is_br),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // v is written slot1..slot4 from MSB to LSB.
    task automatic drive_bundle(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
        in_vld1 = v[3]; in_vld2 = v[2]; in_vld3 = v[1]; in_vld4 = v[0];
        in_ins1 = a;    in_ins2 = b;    in_ins3 = c;    in_ins4 = d;
    endtask

    task automatic idle();
        drive_bundle(4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        flush   = 1'b0;
        out_rdy = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        chk_cnt++;
        if (act !== exp_v) begin
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick(); tick();
        chk("reset_out_vld", 16'(out_vld), 16'd0);
        chk("reset_count",   16'(count),   16'd0);
        chk("reset_in_rdy",  16'(in_rdy),  16'd1);
        chk("reset_is_br",   16'(out_is_br), 16'd0);
        rst_n = 1'b1;
        tick();
        drive_bundle(4'b1111, 16'h2001, 16'h2002, 16'h2003, 16'h2004);
        tick();
        idle();
        chk("pre_reset_count", 16'(count), 16'd4);
        rst_n = 1'b0;
        #1;
        chk("midreset_count",   16'(count),   16'd0);
        chk("midreset_out_vld", 16'(out_vld), 16'd0);
        chk("midreset_in_rdy",  16'(in_rdy),  16'd1);
        tick();
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        tick(); tick();
        chk("postreset_out_vld", 16'(out_vld), 16'd0);
        chk("postreset_count",   16'(count),   16'd0);
        idle();
    endtask

    task automatic test_holes();
        drive_bundle(4'b1010, 16'hA001, 16'hB002, 16'hC003, 16'hD004);
        tick();
        idle();
        out_rdy = 1'b1;
        chk("holes_count2", 16'(count), 16'd2);
        chk("holes_first",  out_ins,    16'hA001);
        tick();
        chk("holes_count1", 16'(count), 16'd1);
        chk("holes_second", out_ins,    16'hC003);
        tick();
        chk("holes_count0", 16'(count), 16'd0);
        chk("holes_empty",  16'(out_vld), 16'd0);
        idle();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive_bundle(4'b1111, 16'h2100 + 16'(4 * i), 16'h2101 + 16'(4 * i),
                         16'h2102 + 16'(4 * i), 16'h2103 + 16'(4 * i));
            tick();
        end
        chk("full_count",  16'(count),  16'd8);
        chk("full_in_rdy", 16'(in_rdy), 16'd0);
        chk("full_head_stable", out_ins, 16'h2100);
        chk("full_not_br", 16'(out_is_br), 16'd0);
        idle();
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        drive_bundle(4'b1111, 16'h2F00, 16'h2F01, 16'h2F02, 16'h2F03);
        #1;
        chk("full_pop_count",  16'(count),  16'd7);
        chk("full_pop_in_rdy", 16'(in_rdy), 16'd0);
        tick();
        idle();
        chk("full_no_accept", 16'(count), 16'd7);
        out_rdy = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("full_drain", out_ins, 16'h2100 + 16'(i));
            tick();
        end
        chk("full_drained", 16'(count), 16'd0);
        idle();
    endtask

    task automatic test_wrap();
        logic [15:0] q[$];
        int sent = 0;
        int popped = 0;
        int cyc = 0;
        out_rdy = 1'b1;
        while ((sent < 20 || q.size() != 0) && cyc < 300) begin
            if (sent < 20) begin
                drive_bundle(4'b0111, 16'hFFFF, 16'h3000 + 16'(3 * sent),
                             16'h3001 + 16'(3 * sent), 16'h3002 + 16'(3 * sent));
            end else begin
                drive_bundle(4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
            end
            #1;
            chk("wrap_count", 16'(count), 16'(q.size()));
            if (q.size() != 0) begin
                chk("wrap_order", out_ins, q[0]);
                void'(q.pop_front());
                popped++;
            end
            if (sent < 20 && in_rdy) begin
                q.push_back(16'h3000 + 16'(3 * sent));
                q.push_back(16'h3001 + 16'(3 * sent));
                q.push_back(16'h3002 + 16'(3 * sent));
                sent++;
            end
            tick();
            cyc++;
        end
        chk("wrap_total", 16'(popped), 16'd60);
        chk("wrap_empty", 16'(out_vld), 16'd0);
        idle();
    endtask

    task automatic test_push_pop();
        drive_bundle(4'b1111, 16'h4000, 16'h4001, 16'h4002, 16'h4003);
        tick();
        chk("pp_count4", 16'(count), 16'd4);
        drive_bundle(4'b1100, 16'h4010, 16'h4011, 16'h4F00, 16'h4F01);
        out_rdy = 1'b1;
        #1;
        chk("pp_in_rdy", 16'(in_rdy), 16'd1);
        tick();
        drive_bundle(4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        out_rdy = 1'b0;
        chk("pp_count5", 16'(count), 16'd5);
        out_rdy = 1'b1;
        chk("pp_o1", out_ins, 16'h4001); tick();
        chk("pp_o2", out_ins, 16'h4002); tick();
        chk("pp_o3", out_ins, 16'h4003); tick();
        chk("pp_o4", out_ins, 16'h4010); tick();
        chk("pp_o5", out_ins, 16'h4011); tick();
        chk("pp_empty", 16'(count), 16'd0);
        idle();
    endtask

    task automatic test_flush();
        drive_bundle(4'b1111, 16'h1ABC, 16'h5001, 16'h5002, 16'h5003);
        tick();
        drive_bundle(4'b1000, 16'h5004, 16'h0000, 16'h0000, 16'h0000);
        tick();
        idle();
        chk("fl_count5", 16'(count), 16'd5);
        chk("fl_is_br",  16'(out_is_br), 16'd1);
        flush   = 1'b1;
        out_rdy = 1'b1;
        drive_bundle(4'b1111, 16'h5100, 16'h5101, 16'h5102, 16'h5103);
        #1;
        chk("fl_in_rdy", 16'(in_rdy), 16'd0);
        tick();
        idle();
        chk("fl_count0",   16'(count),     16'd0);
        chk("fl_out_vld",  16'(out_vld),   16'd0);
        chk("fl_is_br_off", 16'(out_is_br), 16'd0);
        tick();
        chk("fl_no_accept", 16'(count), 16'd0);
        drive_bundle(4'b0001, 16'h0000, 16'h0000, 16'h0000, 16'h6000);
        tick();
        idle();
        chk("fl_refill_count", 16'(count), 16'd1);
        chk("fl_refill_head",  out_ins,    16'h6000);
        out_rdy = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_holes();
        test_full();
        test_wrap();
        test_push_pop();
        test_flush();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
